// File: rtl/evaluate_castling_pipe_pkg.sv
// Shared definitions for the castling-safety evaluator: board geometry,
// piece codes, castle-right bit indices, home squares and FSM states.
package evaluate_castling_pipe_pkg;

    localparam int PIECE_WIDTH = 4;
    localparam int SQ_COUNT    = 64;
    localparam int BOARD_WIDTH = SQ_COUNT * PIECE_WIDTH;

    typedef logic [PIECE_WIDTH-1:0] piece_t;
    typedef logic [5:0]             square_t;

    // Piece codes: bit 3 marks a black piece, bits 2:0 the piece type.
    localparam piece_t EMPTY    = 4'd0;
    localparam piece_t W_PAWN   = 4'd1;
    localparam piece_t W_KNIGHT = 4'd2;
    localparam piece_t W_BISHOP = 4'd3;
    localparam piece_t W_ROOK   = 4'd4;
    localparam piece_t W_QUEEN  = 4'd5;
    localparam piece_t W_KING   = 4'd6;
    localparam piece_t B_PAWN   = 4'd9;
    localparam piece_t B_KNIGHT = 4'd10;
    localparam piece_t B_BISHOP = 4'd11;
    localparam piece_t B_ROOK   = 4'd12;
    localparam piece_t B_QUEEN  = 4'd13;
    localparam piece_t B_KING   = 4'd14;

    // Castle-right bit positions within the 4-bit rights masks.
    localparam int CASTLE_WK = 0;
    localparam int CASTLE_WQ = 1;
    localparam int CASTLE_BK = 2;
    localparam int CASTLE_BQ = 3;

    // Home and castled king squares (index = rank*8 + file, a1 = 0).
    localparam square_t SQ_C1 = 6'd2;
    localparam square_t SQ_E1 = 6'd4;
    localparam square_t SQ_G1 = 6'd6;
    localparam square_t SQ_C8 = 6'd58;
    localparam square_t SQ_E8 = 6'd60;
    localparam square_t SQ_G8 = 6'd62;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } castle_state_t;

    // Features extracted from the board in stage 2 for one side.
    // Rights pairs are packed as {queenside, kingside}.
    typedef struct packed {
        logic       enemy_queen;
        logic       king_found;
        square_t    king_sq;
        logic [1:0] rights_orig;
        logic [1:0] rights_cur;
    } castle_feat_t;

    function automatic piece_t square_piece(input logic [BOARD_WIDTH-1:0] board,
                                            input int sq);
        return board[sq*PIECE_WIDTH +: PIECE_WIDTH];
    endfunction

endpackage

// File: rtl/evaluate_castling_pipe_if.sv
// Board-in / score-out handshake bundle of the castling evaluator.
interface evaluate_castling_pipe_if
    import evaluate_castling_pipe_pkg::*;
#(
    parameter int EVAL_WIDTH = 24
) ();
    logic                   board_valid;
    logic [BOARD_WIDTH-1:0] board;
    logic [3:0]             castle_mask;
    logic [3:0]             castle_mask_orig;
    logic                   clear_eval;
    logic [EVAL_WIDTH-1:0]  eval_mg;
    logic                   eval_valid;
    logic                   busy;

    modport master (
        output board_valid, board, castle_mask, castle_mask_orig, clear_eval,
        input  eval_mg, eval_valid, busy
    );

    modport slave (
        input  board_valid, board, castle_mask, castle_mask_orig, clear_eval,
        output eval_mg, eval_valid, busy
    );
endinterface

// File: rtl/castle_latency_fsm.sv
// IDLE/RUN/DONE sequencer that times a fixed evaluation latency.
// A strobe always (re)starts the count; clear_eval aborts or retires a result.
module castle_latency_fsm
    import evaluate_castling_pipe_pkg::*;
#(
    parameter int LATENCY_COUNT = 7
) (
    input  logic clk,
    input  logic reset_n,
    input  logic board_valid,
    input  logic clear_eval,
    output logic busy,
    output logic eval_valid,
    output logic load_result
);
    localparam logic [3:0] CNT_LAST = 4'(LATENCY_COUNT - 1);

    castle_state_t state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    cnt_inc;

    assign cnt_inc = cnt_q + 4'd1;

    // State and cycle-counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; a new board strobe overrides any clear or count.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_result = 1'b0;
        if (board_valid) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_RUN: begin
                    if (clear_eval) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_LAST) begin
                        // The count reaching its last value ends the run.
                        state_d     = ST_DONE;
                        cnt_d       = '0;
                        load_result = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_DONE: begin
                    if (clear_eval) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign busy       = (state_q == ST_RUN);
    assign eval_valid = (state_q == ST_DONE);

endmodule

// File: rtl/evaluate_castling_pipe.sv
// Castling-safety midgame term for one side: castled-king bonus, lost-rights
// penalty, doubled (shifted) while the enemy queen remains on the board.
module evaluate_castling_pipe
    import evaluate_castling_pipe_pkg::*;
#(
    parameter int EVAL_WIDTH     = 24,
    parameter int WHITE_CASTLING = 1,
    parameter int LATENCY_COUNT  = 7,
    parameter int CASTLED_BONUS  = 40,
    parameter int LOST_PENALTY   = 25,
    parameter int QUEEN_SHIFT    = 1
) (
    input logic                     clk,
    input logic                     reset_n,
    evaluate_castling_pipe_if.slave bus
);
    localparam bit      IS_WHITE    = (WHITE_CASTLING != 0);
    localparam int      KS_BIT      = IS_WHITE ? CASTLE_WK : CASTLE_BK;
    localparam int      QS_BIT      = IS_WHITE ? CASTLE_WQ : CASTLE_BQ;
    localparam piece_t  OWN_KING    = IS_WHITE ? W_KING : B_KING;
    localparam piece_t  ENEMY_QUEEN = IS_WHITE ? B_QUEEN : W_QUEEN;
    localparam square_t KS_SQ       = IS_WHITE ? SQ_G1 : SQ_G8;
    localparam square_t QS_SQ       = IS_WHITE ? SQ_C1 : SQ_C8;

    // Headroom for bonus/penalty, shift and negation before saturation.
    localparam int TW = EVAL_WIDTH + 4;
    localparam logic signed [TW-1:0] SAT_MAX = TW'((64'sd1 <<< (EVAL_WIDTH - 1)) - 64'sd1);
    localparam logic signed [TW-1:0] SAT_MIN = -SAT_MAX - TW'(1);

    logic                   busy;
    logic                   eval_valid;
    logic                   load_result;

    logic [BOARD_WIDTH-1:0] board_q;
    logic [1:0]             orig_q;
    logic [1:0]             cur_q;
    castle_feat_t           feat_d, feat_q;
    logic signed [EVAL_WIDTH-1:0] term_d, term_q;
    logic signed [EVAL_WIDTH-1:0] eval_mg_q;

    logic                   ks_lost, qs_lost, castled;
    logic signed [TW-1:0]   base_term, shifted_term, side_term;

    castle_latency_fsm #(
        .LATENCY_COUNT (LATENCY_COUNT)
    ) u_fsm (
        .clk         (clk),
        .reset_n     (reset_n),
        .board_valid (bus.board_valid),
        .clear_eval  (bus.clear_eval),
        .busy        (busy),
        .eval_valid  (eval_valid),
        .load_result (load_result)
    );

    // Stage 1: capture the board and this side's rights on the strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the wide board register is reset too, so a stale position
            // can never leak into a score after reset.
            board_q <= '0;
            orig_q  <= '0;
            cur_q   <= '0;
        end else if (bus.board_valid) begin
            board_q <= bus.board;
            orig_q  <= {bus.castle_mask_orig[QS_BIT], bus.castle_mask_orig[KS_BIT]};
            cur_q   <= {bus.castle_mask[QS_BIT], bus.castle_mask[KS_BIT]};
        end
    end

    // Stage 2 scan: enemy queen presence and the lowest-indexed own king.
    always_comb begin
        feat_d             = '0;
        feat_d.rights_orig = orig_q;
        feat_d.rights_cur  = cur_q;
        // Scanning downward lets the lowest matching square win.
        for (int sq = SQ_COUNT - 1; sq >= 0; sq--) begin
            if (square_piece(board_q, sq) == ENEMY_QUEEN) feat_d.enemy_queen = 1'b1;
            if (square_piece(board_q, sq) == OWN_KING) begin
                feat_d.king_found = 1'b1;
                feat_d.king_sq    = square_t'(sq);
            end
        end
    end

    // Stage 3 arithmetic: bonus or penalties, queen shift, side sign, saturate.
    always_comb begin
        // A right only counts as lost if it existed at the root; rights that
        // appear from nowhere contribute nothing.
        ks_lost   = feat_q.rights_orig[0] & ~feat_q.rights_cur[0];
        qs_lost   = feat_q.rights_orig[1] & ~feat_q.rights_cur[1];
        castled   = feat_q.king_found &&
                    ((feat_q.king_sq == KS_SQ && ks_lost) ||
                     (feat_q.king_sq == QS_SQ && qs_lost));
        base_term = '0;
        if (castled) begin
            base_term = TW'(CASTLED_BONUS);
        end else begin
            if (ks_lost) base_term = base_term - TW'(LOST_PENALTY);
            if (qs_lost) base_term = base_term - TW'(LOST_PENALTY);
        end
        shifted_term = feat_q.enemy_queen ? (base_term <<< QUEEN_SHIFT) : base_term;
        side_term    = IS_WHITE ? shifted_term : -shifted_term;
        if (side_term > SAT_MAX)      term_d = SAT_MAX[EVAL_WIDTH-1:0];
        else if (side_term < SAT_MIN) term_d = SAT_MIN[EVAL_WIDTH-1:0];
        else                          term_d = side_term[EVAL_WIDTH-1:0];
    end

    // Stage 2/3 pipeline registers run freely; only the strobe changes stage 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            feat_q <= '0;
            term_q <= '0;
        end else begin
            feat_q <= feat_d;
            term_q <= term_d;
        end
    end

    // Result register: loaded on entry to DONE, held while eval_valid is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         eval_mg_q <= '0;
        else if (load_result) eval_mg_q <= term_q;
    end

    assign bus.eval_mg    = eval_mg_q;
    assign bus.eval_valid = eval_valid;
    assign bus.busy       = busy;

endmodule

// File: tb/tb_evaluate_castling_pipe.sv
// Directed bench for evaluate_castling_pipe: three instances (white 24-bit,
// black 24-bit, white 6-bit) share one stimulus stream.
module tb_evaluate_castling_pipe;
    import evaluate_castling_pipe_pkg::*;

    localparam int LAT = 7;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic                   bv = 1'b0;
    logic                   clr = 1'b0;
    logic [BOARD_WIDTH-1:0] board = '0;
    logic [3:0]             cur = '0;
    logic [3:0]             orig = '0;

    int n_vec = 0;
    int n_err = 0;

    evaluate_castling_pipe_if #(.EVAL_WIDTH(24)) ifw ();
    evaluate_castling_pipe_if #(.EVAL_WIDTH(24)) ifb ();
    evaluate_castling_pipe_if #(.EVAL_WIDTH(6))  ifs ();

    assign ifw.board_valid = bv;  assign ifb.board_valid = bv;  assign ifs.board_valid = bv;
    assign ifw.clear_eval  = clr; assign ifb.clear_eval  = clr; assign ifs.clear_eval  = clr;
    assign ifw.board       = board; assign ifb.board     = board; assign ifs.board     = board;
    assign ifw.castle_mask = cur; assign ifb.castle_mask = cur; assign ifs.castle_mask = cur;
    assign ifw.castle_mask_orig = orig;
    assign ifb.castle_mask_orig = orig;
    assign ifs.castle_mask_orig = orig;

    evaluate_castling_pipe #(.EVAL_WIDTH(24), .WHITE_CASTLING(1), .LATENCY_COUNT(LAT),
        .CASTLED_BONUS(40), .LOST_PENALTY(25), .QUEEN_SHIFT(1))
        dut_w (.clk(clk), .reset_n(reset_n), .bus(ifw));
    evaluate_castling_pipe #(.EVAL_WIDTH(24), .WHITE_CASTLING(0), .LATENCY_COUNT(LAT),
        .CASTLED_BONUS(40), .LOST_PENALTY(25), .QUEEN_SHIFT(1))
        dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));
    evaluate_castling_pipe #(.EVAL_WIDTH(6), .WHITE_CASTLING(1), .LATENCY_COUNT(LAT),
        .CASTLED_BONUS(40), .LOST_PENALTY(25), .QUEEN_SHIFT(1))
        dut_s (.clk(clk), .reset_n(reset_n), .bus(ifs));

    function automatic logic [BOARD_WIDTH-1:0] put(input logic [BOARD_WIDTH-1:0] b,
                                                   input int sq, input piece_t p);
        b[sq*PIECE_WIDTH +: PIECE_WIDTH] = p;
        return b;
    endfunction

    // Position presets.
    function automatic logic [BOARD_WIDTH-1:0] board_castled_g1();
        return put(put('0, SQ_G1, W_KING), SQ_E8, B_KING);
    endfunction
    function automatic logic [BOARD_WIDTH-1:0] board_e1_bq_d8();
        return put(put(put('0, SQ_E1, W_KING), SQ_E8, B_KING), 59, B_QUEEN);
    endfunction

    task automatic set_position(input logic [BOARD_WIDTH-1:0] b, input logic [3:0] o,
                                input logic [3:0] c);
        board = b;
        orig  = o;
        cur   = c;
    endtask

    // Called at a falling edge; pulses board_valid across one rising edge.
    task automatic strobe();
        bv = 1'b1;
        @(negedge clk);
        bv = 1'b0;
    endtask

    task automatic clear_all();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++; if (ifw.eval_mg !== 24'd0) begin n_err++; $display("FAIL reset_mg: got %0d want 0", $signed(ifw.eval_mg)); end
        n_vec++; if (ifw.eval_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ifw.eval_valid); end
        n_vec++; if (ifw.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", ifw.busy); end
        n_vec++; if (ifs.eval_mg !== 6'd0 || ifb.eval_mg !== 24'd0) begin n_err++; $display("FAIL reset_mg_other: got %0d/%0d want 0/0", $signed(ifs.eval_mg), $signed(ifb.eval_mg)); end
    endtask

    task automatic test_castled_kingside();
        set_position(board_castled_g1(), 4'b1111, 4'b1100);
        strobe();
        for (int k = 1; k < LAT; k++) begin
            n_vec++;
            if (ifw.eval_valid !== 1'b0 || ifw.busy !== 1'b1) begin
                n_err++; $display("FAIL castled_latency t+%0d: valid=%b busy=%b want 0/1", k, ifw.eval_valid, ifw.busy);
            end
            @(negedge clk);
        end
        n_vec++; if (ifw.eval_valid !== 1'b1 || ifw.busy !== 1'b0) begin n_err++; $display("FAIL castled_done: valid=%b busy=%b want 1/0", ifw.eval_valid, ifw.busy); end
        n_vec++; if (ifw.eval_mg !== 24'd40) begin n_err++; $display("FAIL castled_mg: got %0d want 40", $signed(ifw.eval_mg)); end
        n_vec++; if (ifb.eval_mg !== 24'd0) begin n_err++; $display("FAIL castled_black_mg: got %0d want 0", $signed(ifb.eval_mg)); end
        repeat (2) @(negedge clk);
        n_vec++; if (ifw.eval_valid !== 1'b1 || ifw.eval_mg !== 24'd40) begin n_err++; $display("FAIL castled_hold: valid=%b mg=%0d want 1/40", ifw.eval_valid, $signed(ifw.eval_mg)); end
        clear_all();
        n_vec++; if (ifw.eval_valid !== 1'b0 || ifw.busy !== 1'b0) begin n_err++; $display("FAIL castled_clear: valid=%b busy=%b want 0/0", ifw.eval_valid, ifw.busy); end
        n_vec++; if (ifw.eval_mg !== 24'd40) begin n_err++; $display("FAIL castled_mg_after_clear: got %0d want 40", $signed(ifw.eval_mg)); end
    endtask

    task automatic test_lost_rights_queen();
        set_position(board_e1_bq_d8(), 4'b0011, 4'b0000);
        strobe();
        repeat (LAT - 1) @(negedge clk);
        n_vec++; if (ifw.eval_valid !== 1'b1 || ifw.eval_mg !== 24'(-100)) begin n_err++; $display("FAIL lost_queen_mg: valid=%b mg=%0d want 1/-100", ifw.eval_valid, $signed(ifw.eval_mg)); end
        n_vec++; if (ifs.eval_mg !== 6'(-32)) begin n_err++; $display("FAIL lost_queen_sat_neg: got %0d want -32", $signed(ifs.eval_mg)); end
        n_vec++; if (ifb.eval_mg !== 24'd0) begin n_err++; $display("FAIL lost_queen_black: got %0d want 0", $signed(ifb.eval_mg)); end
        clear_all();
    endtask

    task automatic test_black_castled();
        set_position(put(put(put('0, SQ_E1, W_KING), SQ_C8, B_KING), 3, W_QUEEN), 4'b1000, 4'b0000);
        strobe();
        repeat (LAT - 1) @(negedge clk);
        n_vec++; if (ifb.eval_valid !== 1'b1 || ifb.eval_mg !== 24'(-80)) begin n_err++; $display("FAIL black_castled_mg: valid=%b mg=%0d want 1/-80", ifb.eval_valid, $signed(ifb.eval_mg)); end
        n_vec++; if (ifw.eval_mg !== 24'd0) begin n_err++; $display("FAIL black_castled_white: got %0d want 0", $signed(ifw.eval_mg)); end
        clear_all();
    endtask

    task automatic test_saturation();
        set_position(put(board_castled_g1(), 59, B_QUEEN), 4'b0001, 4'b0000);
        strobe();
        repeat (LAT - 1) @(negedge clk);
        n_vec++; if (ifs.eval_valid !== 1'b1 || ifs.eval_mg !== 6'sd31) begin n_err++; $display("FAIL sat_pos: valid=%b mg=%0d want 1/31", ifs.eval_valid, $signed(ifs.eval_mg)); end
        n_vec++; if (ifw.eval_mg !== 24'd80) begin n_err++; $display("FAIL sat_wide: got %0d want 80", $signed(ifw.eval_mg)); end
        clear_all();
    endtask

    task automatic test_partial_and_illegal();
        // King on g1 but kingside right still held: only the queenside loss counts.
        set_position(board_castled_g1(), 4'b0011, 4'b0001);
        strobe();
        repeat (LAT - 1) @(negedge clk);
        n_vec++; if (ifw.eval_mg !== 24'(-25)) begin n_err++; $display("FAIL partial_lost: got %0d want -25", $signed(ifw.eval_mg)); end
        // Rights present now but absent at the root contribute nothing.
        set_position(put('0, SQ_E1, W_KING), 4'b0000, 4'b0011);
        strobe();
        repeat (LAT - 1) @(negedge clk);
        n_vec++; if (ifw.eval_valid !== 1'b1 || ifw.eval_mg !== 24'd0) begin n_err++; $display("FAIL illegal_rights: valid=%b mg=%0d want 1/0", ifw.eval_valid, $signed(ifw.eval_mg)); end
        clear_all();
    endtask

    task automatic test_back_to_back();
        set_position(board_castled_g1(), 4'b1111, 4'b1100);
        strobe();                           // strobe at t, now t+1
        repeat (2) @(negedge clk);          // t+3
        set_position(board_e1_bq_d8(), 4'b0011, 4'b0000);
        strobe();                           // restart at t+3, now t+4
        for (int k = 4; k < 3 + LAT; k++) begin
            n_vec++;
            if (ifw.eval_valid !== 1'b0 || ifw.busy !== 1'b1) begin
                n_err++; $display("FAIL restart_quiet t+%0d: valid=%b busy=%b want 0/1", k, ifw.eval_valid, ifw.busy);
            end
            @(negedge clk);
        end
        n_vec++; if (ifw.eval_valid !== 1'b1 || ifw.eval_mg !== 24'(-100)) begin n_err++; $display("FAIL restart_result: valid=%b mg=%0d want 1/-100", ifw.eval_valid, $signed(ifw.eval_mg)); end
    endtask

    task automatic test_clear_and_valid_same_cycle();
        // Enter from DONE (-100 held); strobe and clear together must restart.
        set_position(board_castled_g1(), 4'b1111, 4'b1100);
        bv  = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        bv  = 1'b0;
        clr = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            n_vec++;
            if (ifw.eval_valid !== 1'b0 || ifw.busy !== 1'b1) begin
                n_err++; $display("FAIL clr_vs_valid t+%0d: valid=%b busy=%b want 0/1", k, ifw.eval_valid, ifw.busy);
            end
            @(negedge clk);
        end
        n_vec++; if (ifw.eval_valid !== 1'b1 || ifw.eval_mg !== 24'd40) begin n_err++; $display("FAIL clr_vs_valid_result: valid=%b mg=%0d want 1/40", ifw.eval_valid, $signed(ifw.eval_mg)); end
        clear_all();
    endtask

    task automatic test_clear_in_run();
        // Held result is 40; an aborted run on the -100 position must not replace it.
        set_position(board_e1_bq_d8(), 4'b0011, 4'b0000);
        strobe();
        @(negedge clk);
        clear_all();
        n_vec++; if (ifw.busy !== 1'b0 || ifw.eval_valid !== 1'b0) begin n_err++; $display("FAIL abort_state: busy=%b valid=%b want 0/0", ifw.busy, ifw.eval_valid); end
        for (int k = 0; k < LAT + 1; k++) begin
            n_vec++;
            if (ifw.eval_valid !== 1'b0) begin n_err++; $display("FAIL abort_no_result cyc %0d: valid=%b want 0", k, ifw.eval_valid); end
            @(negedge clk);
        end
        n_vec++; if (ifw.eval_mg !== 24'd40) begin n_err++; $display("FAIL abort_mg: got %0d want 40", $signed(ifw.eval_mg)); end
    endtask

    task automatic test_reset_mid_run();
        set_position(board_e1_bq_d8(), 4'b0011, 4'b0000);
        strobe();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if (ifw.eval_valid !== 1'b0 || ifw.busy !== 1'b0) begin n_err++; $display("FAIL async_reset_ctl: valid=%b busy=%b want 0/0", ifw.eval_valid, ifw.busy); end
        n_vec++; if (ifw.eval_mg !== 24'd0) begin n_err++; $display("FAIL async_reset_mg: got %0d want 0", $signed(ifw.eval_mg)); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        n_vec++; if (ifw.eval_valid !== 1'b0 || ifw.busy !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: valid=%b busy=%b want 0/0", ifw.eval_valid, ifw.busy); end
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_castled_kingside();
        test_lost_rights_queen();
        test_black_castled();
        test_saturation();
        test_partial_and_illegal();
        test_back_to_back();
        test_clear_and_valid_same_cycle();
        test_clear_in_run();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
